pipeline_id_stage: RTL and testbench
====================================

# pipeline_id_stage

Instruction-decode (ID) stage of the in-order RV32I integer pipeline, sitting between IF and EX. It holds the 32×32 architectural register file and decodes the fetched instruction into operands, immediate and control signals. Operand values come from EX-stage forwarding, then an optional writeback bypass, then the register file, all in the same cycle.

## Interface
- Parameters: none. Widths come from the shared `define.h`:
  - `COMMON_WIDTH` = 32 bits.
  - `REG_NUM_WIDTH` = 5 bits.
  - `REG_NUM` = 32.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Ports:
  - clk  in  1  pipeline clock; register-file writes on rising edge
  - rst  in  1  asynchronous active-high reset
  - inst  in  32  instruction from IF
  - reg_forward_ex  in  5  destination register of the instruction in EX
  - data_forward_ex  in  32  EX result for reg_forward_ex
  - wb_we  in  1  writeback write enable
  - wb_rd  in  5  writeback destination register
  - wb_data  in  32  writeback data
  - src1  out  32  resolved rs1 operand
  - src2  out  32  resolved rs2 operand
  - imm  out  32  sign-extended immediate
  - rd  out  5  destination register, inst[11:7]
  - alu_op  out  4  ALU operation code
  - alu_src_imm  out  1  ALU B operand is imm
  - reg_write  out  1  instruction writes rd
  - mem_read  out  1  load
  - mem_write  out  1  store
  - branch  out  1  conditional branch
  - jump  out  1  JAL/JALR
  - illegal  out  1  unsupported opcode
- The register file is an instance named `reg_file` with array `regs[0:31]`; benches poke it hierarchically.

## Operation
- Field extraction:
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
- Operand resolution for each of src1/src2, highest priority first:
  - If the index ≠ 0 and equals reg_forward_ex: data_forward_ex.
  - Else, only with WB bypass compiled in: if wb_we and wb_rd ≠ 0 and wb_rd equals the index: wb_data.
  - Else: regs[index].
- Index 0 always reads 0.
- Forward select must use priority if/else. An unknown (X) reg_forward_ex falls through to the register-file value.
- Register file:
  - Write of wb_data to regs[wb_rd] on posedge clk when wb_we and wb_rd ≠ 0.
  - Writes to x0 are ignored.
- Immediate, by opcode, sign-extended from inst[31]:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - U: LUI, AUIPC; imm = inst[31:12] << 12.
  - J: JAL, bit0 = 0.
  - R-type: imm = 0.
- alu_op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - SUB/SRA are selected by inst[30] for R-type; SRA also for OP-IMM shifts.
  - LOAD/STORE/JAL/JALR/AUIPC use ADD; LUI uses PASSB.
  - BRANCH uses SUB, or SLT/SLTU for BLT/BGE and BLTU/BGEU.
- Control outputs per opcode:
  - reg_write: R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
  - alu_src_imm: all except R-type and BRANCH.
  - mem_read: LOAD.
  - mem_write: STORE.
  - branch: BRANCH.
  - jump: JAL, JALR.
- Unknown opcode: illegal = 1, all other control outputs 0, imm = 0.

## Timing
- Decode and operand resolution are purely combinational: zero-cycle latency from inst, forward and WB inputs to outputs.
- Register-file write takes effect after the rising clk edge. Without the bypass, a same-cycle read returns the old value.
- While rst = 1:
  - All regs clear to 0 asynchronously.
  - All outputs read 0 (src1, src2, imm, rd, alu_op, every control bit, illegal).
- Outputs are valid combinationally once rst deasserts; no clock edge is required.
- Simultaneous EX forward and WB match on the same index: the EX forward wins.
- Hierarchical writes into reg_file.regs after reset persist until overwritten or reset.

## Configuration
- Macro `ID_WB_BYPASS_EN`.
- Defined: the writeback port is bypassed combinationally into src1/src2 when wb_rd matches, at priority below the EX forward.
- Undefined: no WB bypass; the operand is the registered value, and new WB data is visible from the cycle after the write edge.

## Test plan
- Reset then release; poke regs[1] = 3; inst = 0x00108133 (add x2,x1,x1), reg_forward_ex = X -> src1 = 3, src2 = 3, rd = 2, alu_op = 0, reg_write = 1.
- Same inst; reg_forward_ex = 1, data_forward_ex = 10 -> src1 = 10, src2 = 10; only regs[1] = 3 nonzero.
- reg_forward_ex = 0, data_forward_ex = 99, inst reading x0 -> src1 = 0.
- wb_we = 1, wb_rd = 5, wb_data = 7, inst rs1 = 5 -> src1 = 7 in the same cycle with the bypass, or after the clock edge without it; wb_rd = 0 leaves regs[0] = 0.
- inst = 0xFFC42483 (lw x9,-4(x8)) -> imm = 0xFFFFFFFC, mem_read = 1, alu_src_imm = 1; inst = 0x0000007F -> illegal = 1, other controls 0.
- Assert rst mid-run -> all regs and outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_id_stage.sv
// RV32I instruction-decode stage: register file, operand forwarding and control decode.
// Optional writeback bypass into src1/src2 is enabled by defining ID_WB_BYPASS_EN.

`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef REG_NUM_WIDTH
`define REG_NUM_WIDTH 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

module IdRegFile (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [`REG_NUM_WIDTH-1:0] waddr_i,
    input  logic [`COMMON_WIDTH-1:0]  wdata_i,
    input  logic [`REG_NUM_WIDTH-1:0] raddr1_i,
    input  logic [`REG_NUM_WIDTH-1:0] raddr2_i,
    output logic [`COMMON_WIDTH-1:0]  rdata1_o,
    output logic [`COMMON_WIDTH-1:0]  rdata2_o
);

    logic [`COMMON_WIDTH-1:0] regs [0:`REG_NUM-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < `REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs[raddr1_i];
    assign rdata2_o = regs[raddr2_i];

endmodule

module pipeline_id_stage (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`COMMON_WIDTH-1:0]  inst,
    input  logic [`REG_NUM_WIDTH-1:0] reg_forward_ex,
    input  logic [`COMMON_WIDTH-1:0]  data_forward_ex,
    input  logic                      wb_we,
    input  logic [`REG_NUM_WIDTH-1:0] wb_rd,
    input  logic [`COMMON_WIDTH-1:0]  wb_data,
    output logic [`COMMON_WIDTH-1:0]  src1,
    output logic [`COMMON_WIDTH-1:0]  src2,
    output logic [`COMMON_WIDTH-1:0]  imm,
    output logic [`REG_NUM_WIDTH-1:0] rd,
    output logic [3:0]                alu_op,
    output logic                      alu_src_imm,
    output logic                      reg_write,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      branch,
    output logic                      jump,
    output logic                      illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [`REG_NUM_WIDTH-1:0] rs1;
    logic [`REG_NUM_WIDTH-1:0] rs2;
    logic [`COMMON_WIDTH-1:0]  rfData1;
    logic [`COMMON_WIDTH-1:0]  rfData2;
    logic [`COMMON_WIDTH-1:0]  opnd1;
    logic [`COMMON_WIDTH-1:0]  opnd2;
    logic [`COMMON_WIDTH-1:0]  decImm;
    logic [3:0]                decAluOp;
    logic                      decAluSrcImm;
    logic                      decRegWrite;
    logic                      decMemRead;
    logic                      decMemWrite;
    logic                      decBranch;
    logic                      decJump;
    logic                      decIllegal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    IdRegFile reg_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rfData1),
        .rdata2_o (rfData2)
    );

    // SUB only exists for register-register ops; SRA is chosen by inst[30] for both shift forms.
    function automatic logic [3:0] aluFromFunct(input logic [2:0] f3, input logic alt, input logic isReg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (isReg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // A non-matching or unknown EX tag falls through to the next source.
    always_comb begin
        opnd1 = rfData1;
        if (rs1 == '0) begin
            opnd1 = '0;
        end else if (rs1 == reg_forward_ex) begin
            opnd1 = data_forward_ex;
`ifdef ID_WB_BYPASS_EN
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs1)) begin
            opnd1 = wb_data;
`endif
        end

        opnd2 = rfData2;
        if (rs2 == '0) begin
            opnd2 = '0;
        end else if (rs2 == reg_forward_ex) begin
            opnd2 = data_forward_ex;
`ifdef ID_WB_BYPASS_EN
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs2)) begin
            opnd2 = wb_data;
`endif
        end
    end

    always_comb begin
        decImm       = '0;
        decAluOp     = ALU_ADD;
        decAluSrcImm = 1'b0;
        decRegWrite  = 1'b0;
        decMemRead   = 1'b0;
        decMemWrite  = 1'b0;
        decBranch    = 1'b0;
        decJump      = 1'b0;
        decIllegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                decRegWrite = 1'b1;
                decAluOp    = aluFromFunct(funct3, inst[30], 1'b1);
            end
            OPC_OPIMM: begin
                decImm       = {{20{inst[31]}}, inst[31:20]};
                decAluOp     = aluFromFunct(funct3, inst[30], 1'b0);
                decAluSrcImm = 1'b1;
                decRegWrite  = 1'b1;
            end
            OPC_LOAD: begin
                decImm       = {{20{inst[31]}}, inst[31:20]};
                decAluSrcImm = 1'b1;
                decRegWrite  = 1'b1;
                decMemRead   = 1'b1;
            end
            OPC_STORE: begin
                decImm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                decAluSrcImm = 1'b1;
                decMemWrite  = 1'b1;
            end
            OPC_BRANCH: begin
                decImm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                decBranch = 1'b1;
                case (funct3)
                    3'b100, 3'b101: decAluOp = ALU_SLT;
                    3'b110, 3'b111: decAluOp = ALU_SLTU;
                    default:        decAluOp = ALU_SUB;
                endcase
            end
            OPC_LUI: begin
                decImm       = {inst[31:12], 12'b0};
                decAluOp     = ALU_PASSB;
                decAluSrcImm = 1'b1;
                decRegWrite  = 1'b1;
            end
            OPC_AUIPC: begin
                decImm       = {inst[31:12], 12'b0};
                decAluSrcImm = 1'b1;
                decRegWrite  = 1'b1;
            end
            OPC_JAL: begin
                decImm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                decAluSrcImm = 1'b1;
                decRegWrite  = 1'b1;
                decJump      = 1'b1;
            end
            OPC_JALR: begin
                decImm       = {{20{inst[31]}}, inst[31:20]};
                decAluSrcImm = 1'b1;
                decRegWrite  = 1'b1;
                decJump      = 1'b1;
            end
            default: begin
                decIllegal = 1'b1;
            end
        endcase
    end

    // Reset forces every output low without waiting for a clock edge.
    always_comb begin
        src1        = '0;
        src2        = '0;
        imm         = '0;
        rd          = '0;
        alu_op      = '0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            src1        = opnd1;
            src2        = opnd2;
            imm         = decImm;
            rd          = inst[11:7];
            alu_op      = decAluOp;
            alu_src_imm = decAluSrcImm;
            reg_write   = decRegWrite;
            mem_read    = decMemRead;
            mem_write   = decMemWrite;
            branch      = decBranch;
            jump        = decJump;
            illegal     = decIllegal;
        end
    end

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Directed self-checking bench for pipeline_id_stage; honours ID_WB_BYPASS_EN if defined.

module tb_pipeline_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [4:0]  reg_forward_ex;
    logic [31:0] data_forward_ex;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;

    int compared;
    int mismatched;

    pipeline_id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .inst            (inst),
        .reg_forward_ex  (reg_forward_ex),
        .data_forward_ex (data_forward_ex),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .src1            (src1),
        .src2            (src2),
        .imm             (imm),
        .rd              (rd),
        .alu_op          (alu_op),
        .alu_src_imm     (alu_src_imm),
        .reg_write       (reg_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .branch          (branch),
        .jump            (jump),
        .illegal         (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instIn, input logic [4:0] fwdReg, input logic [31:0] fwdData);
        inst            = instIn;
        reg_forward_ex  = fwdReg;
        data_forward_ex = fwdData;
        #1;
    endtask

    initial begin
        int nonzero;
        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        inst            = 32'h0010_8133;
        reg_forward_ex  = 5'd0;
        data_forward_ex = 32'd0;
        wb_we           = 1'b0;
        wb_rd           = 5'd0;
        wb_data         = 32'd0;
        #2;
        checkOutput("rstSrc1", src1, 32'd0);
        checkOutput("rstRd", {27'd0, rd}, 32'd0);
        checkOutput("rstAluOp", {28'd0, alu_op}, 32'd0);
        checkOutput("rstRegWrite", {31'd0, reg_write}, 32'd0);
        checkOutput("rstReg1", dut.reg_file.regs[1], 32'd0);

        @(negedge clk);
        rst = 1'b0;
        dut.reg_file.regs[1] = 32'd3;
        applyStimulus(32'h0010_8133, 5'bx, 32'd0);
        checkOutput("addSrc1", src1, 32'd3);
        checkOutput("addSrc2", src2, 32'd3);
        checkOutput("addRd", {27'd0, rd}, 32'd2);
        checkOutput("addAluOp", {28'd0, alu_op}, 32'd0);
        checkOutput("addRegWrite", {31'd0, reg_write}, 32'd1);
        checkOutput("addAluSrcImm", {31'd0, alu_src_imm}, 32'd0);

        applyStimulus(32'h0010_8133, 5'd1, 32'd10);
        checkOutput("fwdSrc1", src1, 32'd10);
        checkOutput("fwdSrc2", src2, 32'd10);
        nonzero = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.reg_file.regs[i] !== 32'd0) nonzero++;
        end
        checkOutput("nonzeroRegs", nonzero, 32'd1);
        checkOutput("reg1Kept", dut.reg_file.regs[1], 32'd3);

        applyStimulus(32'h0000_01B3, 5'd0, 32'd99);
        checkOutput("x0Src1", src1, 32'd0);
        checkOutput("x0Src2", src2, 32'd0);

        @(negedge clk);
        wb_we   = 1'b1;
        wb_rd   = 5'd5;
        wb_data = 32'd7;
        applyStimulus(32'h0002_8313, 5'd0, 32'd0);
`ifdef ID_WB_BYPASS_EN
        checkOutput("wbSameCycle", src1, 32'd7);
`else
        checkOutput("wbSameCycle", src1, 32'd0);
`endif
        checkOutput("addiAluSrcImm", {31'd0, alu_src_imm}, 32'd1);
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        #1;
        checkOutput("wbAfterEdge", src1, 32'd7);
        checkOutput("wbReg5", dut.reg_file.regs[5], 32'd7);

        @(negedge clk);
        wb_we   = 1'b1;
        wb_rd   = 5'd0;
        wb_data = 32'd55;
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        checkOutput("x0WriteIgnored", dut.reg_file.regs[0], 32'd0);

        applyStimulus(32'hFFC4_2483, 5'd0, 32'd0);
        checkOutput("lwImm", imm, 32'hFFFF_FFFC);
        checkOutput("lwMemRead", {31'd0, mem_read}, 32'd1);
        checkOutput("lwAluSrcImm", {31'd0, alu_src_imm}, 32'd1);
        checkOutput("lwRd", {27'd0, rd}, 32'd9);

        applyStimulus(32'h4020_8533, 5'd0, 32'd0);
        checkOutput("subAluOp", {28'd0, alu_op}, 32'd1);
        checkOutput("subSrc1", src1, 32'd3);

        applyStimulus(32'hFE20_CCE3, 5'd0, 32'd0);
        checkOutput("bltImm", imm, 32'hFFFF_FFF8);
        checkOutput("bltAluOp", {28'd0, alu_op}, 32'd3);
        checkOutput("bltBranch", {31'd0, branch}, 32'd1);
        checkOutput("bltRegWrite", {31'd0, reg_write}, 32'd0);
        checkOutput("bltAluSrcImm", {31'd0, alu_src_imm}, 32'd0);

        applyStimulus(32'h1234_52B7, 5'd0, 32'd0);
        checkOutput("luiImm", imm, 32'h1234_5000);
        checkOutput("luiAluOp", {28'd0, alu_op}, 32'd10);

        applyStimulus(32'h0080_00EF, 5'd0, 32'd0);
        checkOutput("jalImm", imm, 32'd8);
        checkOutput("jalJump", {31'd0, jump}, 32'd1);

        applyStimulus(32'h4030_D393, 5'd0, 32'd0);
        checkOutput("sraiAluOp", {28'd0, alu_op}, 32'd7);
        checkOutput("sraiImm", imm, 32'h0000_0403);

        applyStimulus(32'h0020_A423, 5'd0, 32'd0);
        checkOutput("swImm", imm, 32'd8);
        checkOutput("swMemWrite", {31'd0, mem_write}, 32'd1);
        checkOutput("swRegWrite", {31'd0, reg_write}, 32'd0);

        applyStimulus(32'h0000_007F, 5'd0, 32'd0);
        checkOutput("illIllegal", {31'd0, illegal}, 32'd1);
        checkOutput("illCtrl", {25'd0, reg_write, alu_src_imm, mem_read, mem_write, branch, jump, 1'b0}, 32'd0);
        checkOutput("illImm", imm, 32'd0);

        @(negedge clk);
        applyStimulus(32'h0010_8133, 5'd0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstSrc1", src1, 32'd0);
        checkOutput("midRstRegWrite", {31'd0, reg_write}, 32'd0);
        checkOutput("midRstRd", {27'd0, rd}, 32'd0);
        checkOutput("midRstReg1", dut.reg_file.regs[1], 32'd0);
        checkOutput("midRstReg5", dut.reg_file.regs[5], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
